// File: rtl/word_memory_responder.sv
// Word responder: serves 16-bit little-endian words from a byte memory in two accesses.
// Define WORD_ALIGN_CHECK_EN to also reject odd byte addresses.
module word_memory_responder #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        req,
    input  logic        wr,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        valid,
    output logic        fault
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   a;
    logic [15:0]     d;
    logic            w;
    logic            flt;
    logic [7:0]      mem [MEM_DEPTH];

    logic            reject;
    logic [AW-1:0]   hi_idx;
    logic [AW-1:0]   idx;
    logic            mem_we;
    logic [7:0]      mem_wbyte;

    always_comb begin
        reject = ({16'h0000, address} >= 32'(MEM_DEPTH));
`ifdef WORD_ALIGN_CHECK_EN
        reject = reject | address[0];
`endif
    end

    // second byte wraps to address 0 at the top of memory
    always_comb begin
        hi_idx    = (a == AW'(MEM_DEPTH - 1)) ? '0 : a + AW'(1);
        idx       = (state == HI) ? hi_idx : a;
        mem_we    = w && !rst && ((state == LO) || (state == HI));
        mem_wbyte = (state == HI) ? d[15:8] : d[7:0];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= mem_wbyte;
        end
    end

    // Ready returns one cycle after the Valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            valid <= 1'b0;
            fault <= 1'b0;
            rdata <= 16'h0000;
            a     <= '0;
            d     <= 16'h0000;
            w     <= 1'b0;
            flt   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        valid <= 1'b0;
                        fault <= 1'b0;
                        ready <= 1'b1;
                    end else if (req) begin
                        a     <= address[AW-1:0];
                        d     <= wdata;
                        w     <= wr;
                        flt   <= reject;
                        ready <= 1'b0;
                        state <= reject ? DONE : LO;
                    end
                end
                LO: begin
                    if (!w) begin
                        rdata[7:0] <= mem[a];
                    end
                    state <= HI;
                end
                HI: begin
                    if (!w) begin
                        rdata[15:8] <= mem[hi_idx];
                    end
                    state <= DONE;
                end
                DONE: begin
                    valid <= 1'b1;
                    fault <= flt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_memory_responder.sv
// Bench for word_memory_responder: directed and random word accesses
// checked against an array-based reference of the byte memory.
module tb_word_memory_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        ready;
    logic [15:0] rdata;
    logic        valid;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [15:0] last_rdata = 16'h0000;

    word_memory_responder #(.MEM_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wdata   (wdata),
        .req     (req),
        .wr      (wr),
        .ready   (ready),
        .rdata   (rdata),
        .valid   (valid),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rejected(input logic [15:0] a);
        bit r;
        r = (int'(a) >= DEPTH);
`ifdef WORD_ALIGN_CHECK_EN
        r = r || (a[0] == 1'b1);
`endif
        return r;
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return {ref_mem[(int'(a) + 1) % DEPTH], ref_mem[int'(a)]};
    endfunction

    task automatic do_op(input logic w, input logic [15:0] a,
                         input logic [15:0] dat);
        bit exp_f;
        int n;
        exp_f = rejected(a);
        @(negedge clk);
        chk("ready_before_req", 32'(ready), 32'd1);
        req = 1'b1;
        wr = w;
        address = a;
        wdata = dat;
        @(posedge clk);
        #1;
        req = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 8);
        chk("latency", 32'(n), exp_f ? 32'd1 : 32'd3);
        chk("fault", 32'(fault), 32'(exp_f));
        chk("ready_low_at_valid", 32'(ready), 32'd0);
        if (!exp_f) begin
            if (w) begin
                ref_mem[int'(a)] = dat[7:0];
                ref_mem[(int'(a) + 1) % DEPTH] = dat[15:8];
            end else begin
                last_rdata = ref_word(a);
            end
        end
        chk("rdata", 32'(rdata), 32'(last_rdata));
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("ready_back", 32'(ready), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] dat;
        logic [15:0] old_word;
        int acc;
        int vc;
        int ovl;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i += 2) begin
            do_op(1'b1, 16'(i), 16'($urandom));
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            ref_mem[i] = ref_mem[i];
        end

        do_op(1'b1, 16'h0010, 16'hBEEF);
        do_op(1'b0, 16'h0010, 16'h0000);
        chk("beef_read", 32'(rdata), 32'h0000BEEF);

        do_op(1'b1, 16'h00FF, 16'h1234);
        do_op(1'b0, 16'h00FF, 16'h0000);
`ifndef WORD_ALIGN_CHECK_EN
        chk("wrap_read", 32'(rdata), 32'h00001234);
`endif
        do_op(1'b0, 16'h0000, 16'h0000);

        do_op(1'b0, 16'h0100, 16'h0000);
        do_op(1'b1, 16'hABCD, 16'h5AA5);
        do_op(1'b0, 16'h00CC, 16'h0000);

        do_op(1'b0, 16'h0011, 16'h0000);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 16'($urandom_range(DEPTH, 65535));
            end else begin
                a = 16'($urandom_range(0, DEPTH - 1));
            end
            do_op(1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        acc = 0;
        vc = 0;
        ovl = 0;
        @(negedge clk);
        req = 1'b1;
        wr = 1'b0;
        address = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            if (ready) acc++;
            if (valid) vc++;
            if (ready && valid) ovl++;
            @(posedge clk);
            @(negedge clk);
        end
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (valid) vc++;
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_valids", 32'(vc), 32'd2);
        chk("b2b_ready_valid_overlap", 32'(ovl), 32'd0);
        last_rdata = ref_word(16'h0040);
        chk("b2b_rdata", 32'(rdata), 32'(last_rdata));

        old_word = ref_word(16'h0020);
        dat = ~old_word;
        @(negedge clk);
        req = 1'b1;
        wr = 1'b1;
        address = 16'h0020;
        wdata = dat;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[16'h20] = dat[7:0];
        last_rdata = 16'h0000;
        vc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (valid) vc++;
        end
        chk("midrst_no_valid", 32'(vc), 32'd0);
        do_op(1'b0, 16'h0020, 16'h0000);
        chk("midrst_partial", 32'(rdata), 32'({old_word[15:8], dat[7:0]}));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
